// File: rtl/game_score_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_score_ctrl_pkg
// Shared definitions for the game-progress tracker and the display controller
// that consumes its outputs: game_state encodings, run limits and a small
// high-water-mark helper used for the score.
// -----------------------------------------------------------------------------
package game_score_ctrl_pkg;

    // game_state encodings seen on the game_state output; 3..7 are illegal
    typedef enum logic [2:0] {
        MAIN_STATE    = 3'd0,
        PLAYING_STATE = 3'd1,
        DEAD_STATE    = 3'd2
    } game_state_e;

    localparam logic [9:0] SCORE_MAX    = 10'd999;
    localparam logic [9:0] COIN_MAX     = 10'd999;
    localparam logic [9:0] CHAR_COST    = 10'd3;
    localparam logic [9:0] POS_MAX      = 10'd1023;
    localparam logic [7:0] DEAD_HOLD    = 8'd3;
    localparam logic [7:0] DEAD_TIMEOUT = 8'd10;

    // Running maximum of cur and cand, clipped to lim.
    function automatic logic [9:0] high_water(
        input logic [9:0] cur,
        input logic [9:0] cand,
        input logic [9:0] lim
    );
        logic [9:0] hi;
        hi = (cand > cur) ? cand : cur;
        return (hi > lim) ? lim : hi;
    endfunction

endpackage

// File: rtl/game_score_ctrl_sat.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up/down counter that saturates at MAX and floors at zero.
// Ports:
//   clk_1      in   clock
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   clr        in   synchronous clear, has priority over inc/dec
//   inc        in   count up by one (ignored when dec is also set)
//   dec        in   count down by one (ignored when inc is also set)
//   count      out  registered count
//   count_next out  value the count takes at the next edge
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk_1,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next count: clear wins, opposing requests cancel, limits hold
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = ZERO;
        end else if (inc && !dec && (count_r < MAX)) begin
            count_next_s = count_r + ONE;
        end else if (dec && !inc && (count_r != ZERO)) begin
            count_next_s = count_r - ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/game_score_ctrl.sv
// -----------------------------------------------------------------------------
// game_score_ctrl
// Game-progress tracker: runs the MAIN -> PLAYING -> DEAD flow, tracks the
// furthest row reached (score), coins collected this run and the character
// chosen at launch. All outputs are registered on clk_1.
// Ports:
//   clk_1       in   game clock
//   rst_n       in   asynchronous active-low reset
//   start       in   start button level (debounced, clk_1 synchronous)
//   char_sel    in   requested character (0 basic, 1 premium)
//   coin_store  in   stored coin balance, read only at launch
//   move_fwd    in   pulse: player stepped forward
//   move_back   in   pulse: player stepped back
//   coin_hit    in   pulse: coin collected
//   collide     in   pulse: player hit an obstacle
//   game_state  out  0 MAIN, 1 PLAYING, 2 DEAD
//   score       out  furthest row reached this run (saturates at 999)
//   coin        out  coins collected this run (saturates at 999)
//   character   out  character latched for the current run
// -----------------------------------------------------------------------------
module game_score_ctrl
    import game_score_ctrl_pkg::*;
(
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic       start,
    input  logic       char_sel,
    input  logic [9:0] coin_store,
    input  logic       move_fwd,
    input  logic       move_back,
    input  logic       coin_hit,
    input  logic       collide,
    output logic [2:0] game_state,
    output logic [9:0] score,
    output logic [9:0] coin,
    output logic       character
);

    game_state_e state_r;
    game_state_e state_next_s;

    logic       start_q_r;
    logic       armed_r;
    logic       start_edge_s;

    logic [9:0] score_r;
    logic [9:0] score_next_s;
    logic       char_r;
    logic       char_next_s;
    logic       shield_r;
    logic       shield_next_s;
    logic [7:0] dead_cnt_r;
    logic [7:0] dead_cnt_next_s;

    logic       in_main_s;
    logic       in_play_s;
    logic       in_dead_s;
    logic       launch_s;
    logic       buy_s;
    logic       dead_exit_s;
    logic       enter_main_s;
    logic       step_fwd_s;
    logic       step_back_s;

    logic [9:0] pos_s;
    logic [9:0] pos_next_s;
    logic [9:0] coin_s;
    logic [9:0] coin_next_s;
    logic       unused_ok_s;

    // Start edge detector. armed_r stays low for the first edge after reset so
    // a button held through reset release is treated as already pressed.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            start_q_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            start_q_r <= start;
            armed_r   <= 1'b1;
        end
    end

    assign start_edge_s = start & ~start_q_r & armed_r;

    assign in_main_s = (state_r == MAIN_STATE);
    assign in_play_s = (state_r == PLAYING_STATE);
    assign in_dead_s = (state_r == DEAD_STATE);
    assign launch_s  = in_main_s & start_edge_s;
    assign buy_s     = char_sel & (coin_store >= CHAR_COST);

    // A move arriving with a collision is discarded; fwd+back cancel in the counter
    assign step_fwd_s  = in_play_s & move_fwd  & ~collide;
    assign step_back_s = in_play_s & move_back & ~collide;

    assign dead_exit_s = (start_edge_s && (dead_cnt_r >= DEAD_HOLD)) ||
                         (dead_cnt_r == (DEAD_TIMEOUT - 8'd1));

    // Game flow next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MAIN_STATE: begin
                if (start_edge_s) begin
                    state_next_s = PLAYING_STATE;
                end else begin
                    state_next_s = MAIN_STATE;
                end
            end
            PLAYING_STATE: begin
                if (collide && !shield_r) begin
                    state_next_s = DEAD_STATE;
                end else begin
                    state_next_s = PLAYING_STATE;
                end
            end
            DEAD_STATE: begin
                if (dead_exit_s) begin
                    state_next_s = MAIN_STATE;
                end else begin
                    state_next_s = DEAD_STATE;
                end
            end
            default: begin
                state_next_s = MAIN_STATE;
            end
        endcase
    end

    // Game state register
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MAIN_STATE;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign enter_main_s = (state_next_s == MAIN_STATE) && !in_main_s;

    // Row position; only the next value feeds the score high-water mark
    sat_counter #(
        .WIDTH (10),
        .MAX   (POS_MAX)
    ) u_pos (
        .clk_1      (clk_1),
        .rst_n      (rst_n),
        .clr        (launch_s),
        .inc        (step_fwd_s),
        .dec        (step_back_s),
        .count      (pos_s),
        .count_next (pos_next_s)
    );

    // Coins this run; a coin arriving with the fatal collision still counts
    sat_counter #(
        .WIDTH (10),
        .MAX   (COIN_MAX)
    ) u_coin (
        .clk_1      (clk_1),
        .rst_n      (rst_n),
        .clr        (launch_s),
        .inc        (in_play_s & coin_hit),
        .dec        (1'b0),
        .count      (coin_s),
        .count_next (coin_next_s)
    );

    assign unused_ok_s = ^{pos_s, coin_next_s};

    // Run datapath: score, character, shield and DEAD dwell counter
    always_comb begin
        score_next_s    = score_r;
        char_next_s     = char_r;
        shield_next_s   = shield_r;
        dead_cnt_next_s = 8'd0;
        if (launch_s) begin
            score_next_s  = 10'd0;
            char_next_s   = buy_s;
            shield_next_s = buy_s;
        end else if (in_play_s) begin
            score_next_s = high_water(score_r, pos_next_s, SCORE_MAX);
            if (collide) begin
                shield_next_s = 1'b0;
            end else begin
                shield_next_s = shield_r;
            end
        end else if (enter_main_s) begin
            char_next_s = 1'b0;
        end else begin
            char_next_s = char_r;
        end
        if (in_dead_s) begin
            dead_cnt_next_s = dead_cnt_r + 8'd1;
        end else begin
            dead_cnt_next_s = 8'd0;
        end
    end

    // Run datapath registers
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            score_r    <= 10'd0;
            char_r     <= 1'b0;
            shield_r   <= 1'b0;
            dead_cnt_r <= 8'd0;
        end else begin
            score_r    <= score_next_s;
            char_r     <= char_next_s;
            shield_r   <= shield_next_s;
            dead_cnt_r <= dead_cnt_next_s;
        end
    end

    assign game_state = state_r;
    assign score      = score_r;
    assign coin       = coin_s;
    assign character  = char_r;

endmodule
